// File: rtl/div_ctrl.sv
// Divide controller: issues DIV/DIVU from execute to an iterative divider, owns HI/LO,
// stalls the pipeline while the divide is outstanding and aborts on divider timeout.
module div_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div,
    input  logic        ex_signed,
    input  logic [31:0] ex_a,
    input  logic [31:0] ex_b,
    input  logic        ex_mthi,
    input  logic        ex_mtlo,
    input  logic [31:0] ex_wdata,
    input  logic        flush,
    output logic        stall,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic        discard;
    logic        issue;
    logic        done_ok;
    logic        timeout;
    logic        mt_wr;

    // Divider handshake: div_start is the request and stays high with stable operands
    // until div_ready is sampled (or timeout); div_ready then stays high until div_start falls.
    always_comb begin
        issue    = (state == IDLE) & ex_div & (ex_b != 32'd0) & ~flush;
        done_ok  = (state == BUSY) & div_ready;
        timeout  = (state == BUSY) & ~div_ready & (cnt == CNT_LAST);
        stall    = issue | (state == BUSY) | ((state == DRAIN) & ex_div);
        mt_wr    = ~stall & ~flush & ~ex_div;
        state_nx = state;
        case (state)
            IDLE:    if (issue) state_nx = BUSY;
            BUSY:    if (done_ok || timeout) state_nx = DRAIN;
            DRAIN:   if (!div_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_start  <= 1'b0;
            div_signed <= 1'b0;
            div_a      <= 32'd0;
            div_b      <= 32'd0;
            cnt        <= 4'd0;
            discard    <= 1'b0;
            div_err    <= 1'b0;
        end else if (issue) begin
            div_start  <= 1'b1;
            div_signed <= ex_signed;
            div_a      <= ex_a;
            div_b      <= ex_b;
            cnt        <= 4'd0;
            discard    <= 1'b0;
        end else if (state == BUSY) begin
            cnt <= cnt + 4'd1;
            if (flush) discard <= 1'b1;
            if (div_ready || timeout) div_start <= 1'b0;
            if (timeout) div_err <= 1'b1;
        end
    end

    // A flush landing in the very cycle the result returns also discards it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (done_ok && !(discard || flush)) begin
            hi <= div_result[63:32];
            lo <= div_result[31:0];
        end else if (mt_wr) begin
            if (ex_mthi) hi <= ex_wdata;
            if (ex_mtlo) lo <= ex_wdata;
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: behavioural 7-cycle divider, op-level HI/LO reference model,
// scoreboard queues checked by a monitor on strobes and on div_start falling.
module tb_div_ctrl;

    localparam int TIMEOUT = 15;
    localparam int DIV_LAT = 7;

    logic        clk;
    logic        rst;
    logic        ex_div, ex_signed, ex_mthi, ex_mtlo, flush;
    logic [31:0] ex_a, ex_b, ex_wdata;
    logic        stall, div_start, div_signed, div_err;
    logic [31:0] div_a, div_b, hi, lo;
    logic        div_ready;
    logic [63:0] div_result;
    logic [1:0]  dbg_state;

    div_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .ex_div(ex_div), .ex_signed(ex_signed),
        .ex_a(ex_a), .ex_b(ex_b), .ex_mthi(ex_mthi), .ex_mtlo(ex_mtlo),
        .ex_wdata(ex_wdata), .flush(flush), .stall(stall), .div_start(div_start),
        .div_signed(div_signed), .div_a(div_a), .div_b(div_b), .div_ready(div_ready),
        .div_result(div_result), .hi(hi), .lo(lo), .div_err(div_err), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          n_vec;
    int          n_err;
    logic [64:0] exp_q[$];     // {div_err, hi, lo} expected at each strobe
    int          lat_q[$];     // expected div_start high cycles per issued divide
    logic [64:0] opd_q[$];     // {signed, a, b} expected on div_* while div_start high
    logic        obs;
    logic        ready_en;
    logic [31:0] hi_m, lo_m;
    logic        err_m;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint na, nb, q, r;
        if (s) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({32'd0, b});
        end
        q = na / nb;
        r = na % nb;
        return {r[31:0], q[31:0]};
    endfunction

    // ---------------- behavioural divider ----------------
    int dcnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            div_ready  <= 1'b0;
            div_result <= 64'd0;
            dcnt       <= 0;
        end else if (!div_start) begin
            div_ready <= 1'b0;
            dcnt      <= 0;
        end else if (!div_ready && ready_en) begin
            if (dcnt == DIV_LAT - 2) begin
                div_ready  <= 1'b1;
                div_result <= ref_div(div_signed, div_a, div_b);
            end else begin
                dcnt <= dcnt + 1;
            end
        end
    end

    // ---------------- monitor ----------------
    int          hi_cnt;
    logic        prev_start;
    logic        opd_bad;
    logic [64:0] opd_seen;
    initial begin
        hi_cnt = 0; prev_start = 1'b0; opd_bad = 1'b0; opd_seen = '0;
    end

    always @(negedge clk) begin
        #4;
        if (obs) begin
            if (exp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL hilo: strobe with empty expected queue");
            end else begin
                check("hilo_err", {div_err, hi, lo}, exp_q.pop_front());
            end
        end
        if (rst) begin
            hi_cnt = 0; prev_start = 1'b0; opd_bad = 1'b0;
        end else begin
            if (div_start) begin
                hi_cnt++;
                if (!opd_bad) opd_seen = {div_signed, div_a, div_b};
                if (opd_q.size() != 0 && opd_seen !== opd_q[0]) opd_bad = 1'b1;
            end else if (prev_start) begin
                if (lat_q.size() == 0 || opd_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL start_len: unexpected div_start pulse of %0d cycles", hi_cnt);
                end else begin
                    check("start_len", hi_cnt, lat_q.pop_front());
                    check("operands", opd_seen, opd_q.pop_front());
                end
                hi_cnt = 0; opd_bad = 1'b0;
            end
            prev_start = div_start;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_op(input logic d, input logic s, input logic mh, input logic ml,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] wd,
                          input logic fl_iss, input int fl_busy, input logic rdy);
        logic done, stall_bad, issued;
        int n;
        @(negedge clk);
        ex_div = d; ex_signed = s; ex_mthi = mh; ex_mtlo = ml;
        ex_a = a; ex_b = b; ex_wdata = wd;
        done = 1'b0; stall_bad = 1'b0; issued = 1'b0; n = 0;
        while (!done && n < 100) begin
            #1;
            if (d ? (dbg_state == 2'd0) : (stall == 1'b0)) begin
                flush = fl_iss;
                if (d) ready_en = rdy;
                #1;
                if (d) check("stall_issue", stall, d & (b != 32'd0) & ~fl_iss);
                exp_q.push_back({err_m, hi_m, lo_m});
                obs = 1'b1;
                if (d && b != 32'd0 && !fl_iss) begin
                    issued = 1'b1;
                    lat_q.push_back(rdy ? DIV_LAT : TIMEOUT);
                    opd_q.push_back({s, a, b});
                    if (!rdy) err_m = 1'b1;
                    else if (fl_busy == 0) {hi_m, lo_m} = ref_div(s, a, b);
                end else if (!d && !fl_iss) begin
                    if (mh) hi_m = wd;
                    if (ml) lo_m = wd;
                end
                done = 1'b1;
            end else if (d && !stall) begin
                stall_bad = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        obs = 1'b0; flush = 1'b0;
        ex_div = 1'b0; ex_mthi = 1'b0; ex_mtlo = 1'b0;
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL op_accept: op not accepted within 100 cycles");
        end
        if (d) check("stall_hold", stall_bad, 1'b0);
        if (issued && fl_busy > 0) begin
            repeat (fl_busy - 1) @(negedge clk);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
        end
    endtask

    task automatic wait_idle_and_check();
        int n;
        n = 0;
        @(negedge clk);
        while (n < 100) begin
            #1;
            if (dbg_state == 2'd0 && !div_ready) break;
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_vec++; n_err++;
            $display("FAIL idle_wait: DUT not idle within 100 cycles");
        end
        #1;
        exp_q.push_back({err_m, hi_m, lo_m});
        obs = 1'b1;
        @(negedge clk);
        obs = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic        d, s, mh, ml, fi;
        logic [31:0] a, b, wd;
        int          fb, sel;
        n_vec = 0; n_err = 0; obs = 1'b0; ready_en = 1'b1;
        hi_m = '0; lo_m = '0; err_m = 1'b0;
        rst = 1'b1; flush = 1'b0;
        ex_div = 1'b0; ex_signed = 1'b0; ex_mthi = 1'b0; ex_mtlo = 1'b0;
        ex_a = '0; ex_b = '0; ex_wdata = '0;
        @(negedge clk); @(negedge clk); #1;
        check("reset_regs", {div_start, div_signed, div_a, div_b, div_err, stall}, '0);
        check("reset_hilo", {hi, lo, dbg_state}, '0);
        rst = 1'b0;

        run_op(1, 0, 0, 0, 32'd7, 32'd2, 0, 0, 0, 1);                  // DIVU 7/2
        run_op(1, 1, 0, 0, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 1);          // DIV -7/2
        run_op(0, 0, 1, 0, 0, 0, 32'h11, 0, 0, 1);                     // MTHI
        run_op(0, 0, 0, 1, 0, 0, 32'h22, 0, 0, 1);                     // MTLO
        run_op(1, 1, 0, 0, 32'd5, 32'd0, 0, 0, 0, 1);                  // divide by zero
        run_op(1, 0, 0, 0, 32'd100, 32'd3, 0, 0, 3, 1);                // flushed in BUSY
        run_op(1, 0, 0, 0, 32'd100, 32'd3, 0, 0, 0, 1);                // back-to-back
        run_op(1, 0, 0, 0, 32'd9, 32'd4, 0, 0, 0, 1);
        run_op(1, 0, 1, 0, 32'd50, 32'd7, 32'h5555, 0, 0, 1);          // DIV beats MTHI
        run_op(0, 0, 1, 1, 0, 0, 32'h77, 1, 0, 1);                     // flushed MT
        run_op(1, 0, 0, 0, 32'd20, 32'd6, 0, 1, 0, 1);                 // flushed at issue
        wait_idle_and_check();

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            d   = (sel < 6);
            s   = $urandom_range(0, 1);
            mh  = (sel == 6 || sel == 8) || (d && $urandom_range(0, 7) == 0);
            ml  = (sel == 7 || sel == 8);
            a   = $urandom;
            b   = ($urandom_range(0, 6) == 0) ? 32'd0 :
                  ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            wd  = $urandom;
            fi  = ($urandom_range(0, 9) == 0);
            fb  = ($urandom_range(0, 6) == 0) ? $urandom_range(1, 6) : 0;
            run_op(d, s, mh, ml, a, b, wd, fi, fb, 1);
        end
        wait_idle_and_check();

        run_op(1, 0, 0, 0, 32'd50, 32'd5, 0, 0, 0, 0);                 // divider never ready
        run_op(0, 0, 1, 0, 0, 0, 32'h0000_ABCD, 0, 0, 1);
        wait_idle_and_check();

        run_op(1, 0, 0, 0, 32'd1000, 32'd7, 0, 0, 0, 1);               // reset mid-BUSY
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_busy_regs", {div_start, div_signed, div_a, div_b, div_err, stall}, '0);
        check("rst_busy_hilo", {hi, lo, dbg_state}, '0);
        lat_q.delete(); opd_q.delete();
        hi_m = '0; lo_m = '0; err_m = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        run_op(1, 0, 0, 0, 32'd81, 32'd9, 0, 0, 0, 1);
        wait_idle_and_check();

        repeat (3) @(negedge clk);
        check("lat_q_drained", lat_q.size(), 0);
        check("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
